// File: rtl/memory_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// memory_access_stage_pkg
// Shared CPU definitions used by the memory-access stage:
//   - opcode field position and the OP_* opcode map (shared with fetch/decode)
//   - IDLE/WAIT/TRAP state encoding of the D-cache controller
//   - trap codes reported on trapCode
// ---------------------------------------------------------------------------
package memory_access_stage_pkg;

  // Opcode field inside the instruction word
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  // Opcode map shared with fetch/decode
  localparam logic [5:0] OP_ADD = 6'h01;
  localparam logic [5:0] OP_LD  = 6'h23;
  localparam logic [5:0] OP_ST  = 6'h2B;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_WAIT = 2'd1,
    MA_TRAP = 2'd2
  } ma_state_e;

  localparam logic [3:0] TRAP_NONE     = 4'd0;
  localparam logic [3:0] TRAP_DATA_ERR = 4'd1;
  localparam logic [3:0] TRAP_MISALIGN = 4'd2;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/memory_access_stage_dcache_ctl.sv
// ---------------------------------------------------------------------------
// ma_dcache_ctl
// D-cache transaction controller for the memory-access stage. Owns the
// IDLE/WAIT/TRAP FSM, the dcReq/dcWr/dcAdr/dcWrData registers and the load
// data buffer.
// Optional feature macro: MA_ALIGN_CHECK_EN
//   defined   : misaligned effective address traps (code 2), no request
//   undefined : no check, address bits [1:0] forced to zero
// Ports:
//   clk, rst        clock, async active-low reset
//   i_half          pipeline half-cycle (0 = issue phase, 1 = commit phase)
//   i_valid/i_opcode/i_val_a/b/x   instruction from fetch/decode
//   dcReq/dcWr/dcAdr/dcWrData      D-cache request side
//   dcAck/dcErr/dcRdData           D-cache response side
//   o_rd_buf        captured load data
//   o_stall         1 while waiting for the cache
//   o_done          strobe: transaction finished without error
//   o_err           strobe: transaction error or misaligned address
//   o_trap          FSM is in TRAP
//   o_trap_code     code to report with the trap pulse
// ---------------------------------------------------------------------------
module ma_dcache_ctl
  import memory_access_stage_pkg::*;
#(
  parameter int WL = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_half,
  input  logic          i_valid,
  input  logic [5:0]    i_opcode,
  input  logic [WL-1:0] i_val_a,
  input  logic [WL-1:0] i_val_b,
  input  logic [WL-1:0] i_val_x,
  output logic          dcReq,
  output logic          dcWr,
  output logic [WL-1:0] dcAdr,
  output logic [WL-1:0] dcWrData,
  input  logic          dcAck,
  input  logic          dcErr,
  input  logic [WL-1:0] dcRdData,
  output logic [WL-1:0] o_rd_buf,
  output logic          o_stall,
  output logic          o_done,
  output logic          o_err,
  output logic          o_trap,
  output logic [3:0]    o_trap_code
);

  ma_state_e     r_state, w_state_nxt;
  logic [WL-1:0] w_sum, w_adr;
  logic          w_misalign, w_start, w_ack;
  logic [3:0]    r_code;

  // Effective address; carry out of the adder is dropped
  assign w_sum = i_val_b + i_val_x;

`ifdef MA_ALIGN_CHECK_EN
  assign w_misalign = (w_sum[1:0] != 2'b00);
  assign w_adr      = w_sum;
`else
  assign w_misalign = 1'b0;
  assign w_adr      = w_sum & {{(WL-2){1'b1}}, 2'b00};
`endif

  // New transaction only on the issue phase of an idle cycle
  assign w_start = (r_state == MA_IDLE) && !i_half && i_valid && is_mem_op(i_opcode);
  // dcAck is only meaningful while waiting; a stray ack elsewhere is ignored
  assign w_ack   = (r_state == MA_WAIT) && dcAck;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= MA_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MA_IDLE: if (w_start) w_state_nxt = w_misalign ? MA_TRAP : MA_WAIT;
      MA_WAIT: if (dcAck)   w_state_nxt = dcErr ? MA_TRAP : MA_IDLE;
      // TRAP is left on the commit edge that reports it
      MA_TRAP: if (i_half)  w_state_nxt = MA_IDLE;
      default:              w_state_nxt = MA_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_stall     = (r_state == MA_WAIT);
    o_done      = w_ack && !dcErr;
    o_err       = (w_ack && dcErr) || (w_start && w_misalign);
    o_trap      = (r_state == MA_TRAP);
    o_trap_code = r_code;
  end

  // Request / address / data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcReq    <= 1'b0;
      dcWr     <= 1'b0;
      dcAdr    <= '0;
      dcWrData <= '0;
      o_rd_buf <= '0;
      r_code   <= TRAP_NONE;
    end else if (w_start) begin
      dcAdr    <= w_adr;
      dcWr     <= (i_opcode == OP_ST);
      dcWrData <= i_val_a;
      dcReq    <= !w_misalign;
      r_code   <= w_misalign ? TRAP_MISALIGN : TRAP_NONE;
    end else if (w_ack) begin
      dcReq    <= 1'b0;
      o_rd_buf <= dcRdData;
      r_code   <= dcErr ? TRAP_DATA_ERR : TRAP_NONE;
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// ---------------------------------------------------------------------------
// memory_access_stage
// Pipeline stage after fetch/decode. LD/ST compute B+X and perform one
// D-cache transaction while stalling fetch/decode; other opcodes pass
// through. One pipeline cycle is two clocks: phase 0 issues, phase 1 commits
// the pipeline registers to execute.
// Optional feature macro: MA_ALIGN_CHECK_EN (misaligned-address trap).
// Parameters: WORD_LENGTH data/address width (>= 32, opcode in [31:26])
// Ports:
//   clk, rst                   clock, async active-low reset
//   inPstate0/1, inInstr       state/instruction from fetch/decode
//   inValA/B/X, inValid        operands and valid
//   outPstate0/1, outInstr     registered to execute
//   outValA/B/X, outValid      A; B or load data; X or effective address
//   stallOut                   hold fetch/decode
//   dcReq/dcWr/dcAdr/dcWrData  D-cache request
//   dcAck/dcErr/dcRdData       D-cache response
//   trapReq, trapCode          one-clock trap pulse and cause
// ---------------------------------------------------------------------------
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] inPstate0,
  input  logic [WORD_LENGTH-1:0] inPstate1,
  input  logic [WORD_LENGTH-1:0] inInstr,
  input  logic [WORD_LENGTH-1:0] inValA,
  input  logic [WORD_LENGTH-1:0] inValB,
  input  logic [WORD_LENGTH-1:0] inValX,
  input  logic                   inValid,
  output logic [WORD_LENGTH-1:0] outPstate0,
  output logic [WORD_LENGTH-1:0] outPstate1,
  output logic [WORD_LENGTH-1:0] outInstr,
  output logic [WORD_LENGTH-1:0] outValA,
  output logic [WORD_LENGTH-1:0] outValB,
  output logic [WORD_LENGTH-1:0] outValX,
  output logic                   outValid,
  output logic                   stallOut,
  output logic                   dcReq,
  output logic                   dcWr,
  output logic [WORD_LENGTH-1:0] dcAdr,
  output logic [WORD_LENGTH-1:0] dcWrData,
  input  logic                   dcAck,
  input  logic                   dcErr,
  input  logic [WORD_LENGTH-1:0] dcRdData,
  output logic                   trapReq,
  output logic [3:0]             trapCode
);

  logic                   r_half;
  logic [5:0]             w_opc;
  logic                   w_is_ld, w_is_mem;
  logic                   w_stall, w_done, w_err, w_trap, w_commit;
  logic [3:0]             w_trap_code;
  logic [WORD_LENGTH-1:0] w_rd_buf;

  assign w_opc    = inInstr[OPC_MSB:OPC_LSB];
  assign w_is_ld  = inValid && (w_opc == OP_LD);
  assign w_is_mem = inValid && is_mem_op(w_opc);
  assign stallOut = w_stall;
  // Commit edge: phase 1 of an unstalled cycle
  assign w_commit = r_half && !w_stall;

  ma_dcache_ctl #(.WL(WORD_LENGTH)) u_dc (
    .clk         (clk),
    .rst         (rst),
    .i_half      (r_half),
    .i_valid     (inValid),
    .i_opcode    (w_opc),
    .i_val_a     (inValA),
    .i_val_b     (inValB),
    .i_val_x     (inValX),
    .dcReq       (dcReq),
    .dcWr        (dcWr),
    .dcAdr       (dcAdr),
    .dcWrData    (dcWrData),
    .dcAck       (dcAck),
    .dcErr       (dcErr),
    .dcRdData    (dcRdData),
    .o_rd_buf    (w_rd_buf),
    .o_stall     (w_stall),
    .o_done      (w_done),
    .o_err       (w_err),
    .o_trap      (w_trap),
    .o_trap_code (w_trap_code)
  );

  // Half-cycle: toggles while running, frozen during a stall. Finishing a
  // transaction (or raising a trap) always lands on the commit phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_half <= 1'b0;
    else if (w_done || w_err) r_half <= 1'b1;
    else if (!w_stall)       r_half <= ~r_half;
  end

  // Pipeline registers and trap pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outPstate0 <= '0;
      outPstate1 <= '0;
      outInstr   <= '0;
      outValA    <= '0;
      outValB    <= '0;
      outValX    <= '0;
      outValid   <= 1'b0;
      trapReq    <= 1'b0;
      trapCode   <= TRAP_NONE;
    end else begin
      trapReq  <= 1'b0;
      trapCode <= TRAP_NONE;
      if (w_commit) begin
        outPstate0 <= inPstate0;
        outPstate1 <= inPstate1;
        outInstr   <= inInstr;
        outValA    <= inValA;
        outValB    <= w_is_ld  ? w_rd_buf : inValB;
        outValX    <= w_is_mem ? dcAdr    : inValX;
        if (w_trap) begin
          outValid <= 1'b0;
          trapReq  <= 1'b1;
          trapCode <= w_trap_code;
        end else begin
          outValid <= inValid;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_access_stage
// Directed vectors with hand-computed expectations for memory_access_stage.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_memory_access_stage;
  import memory_access_stage_pkg::*;

  localparam int WL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [WL-1:0] inPstate0, inPstate1, inInstr, inValA, inValB, inValX;
  logic          inValid;
  logic [WL-1:0] outPstate0, outPstate1, outInstr, outValA, outValB, outValX;
  logic          outValid, stallOut, dcReq, dcWr;
  logic [WL-1:0] dcAdr, dcWrData, dcRdData;
  logic          dcAck, dcErr, trapReq;
  logic [3:0]    trapCode;

  int n_chk  = 0;
  int n_fail = 0;
  int stall_clks;

  memory_access_stage #(.WORD_LENGTH(WL)) dut (
    .clk(clk), .rst(rst),
    .inPstate0(inPstate0), .inPstate1(inPstate1), .inInstr(inInstr),
    .inValA(inValA), .inValB(inValB), .inValX(inValX), .inValid(inValid),
    .outPstate0(outPstate0), .outPstate1(outPstate1), .outInstr(outInstr),
    .outValA(outValA), .outValB(outValB), .outValX(outValX), .outValid(outValid),
    .stallOut(stallOut), .dcReq(dcReq), .dcWr(dcWr), .dcAdr(dcAdr),
    .dcWrData(dcWrData), .dcAck(dcAck), .dcErr(dcErr), .dcRdData(dcRdData),
    .trapReq(trapReq), .trapCode(trapCode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] x, input logic v);
    inInstr   = {op, 26'h0ABCDE};
    inPstate0 = {24'h0, 2'b00, op};
    inPstate1 = 32'hC0DE0000 | a;
    inValA    = a;
    inValB    = b;
    inValX    = x;
    inValid   = v;
  endtask

  // Called after the issue edge; ack is sampled on the n-th edge after dcReq rose
  task automatic mem_wait(input int n, input logic [31:0] rd, input logic err, output int sc);
    sc = 0;
    for (int i = 1; i < n; i++) begin
      if (stallOut) sc++;
      tick();
    end
    if (stallOut) sc++;
    dcAck = 1'b1; dcErr = err; dcRdData = rd;
    tick();
    dcAck = 1'b0; dcErr = 1'b0; dcRdData = '0;
  endtask

  initial begin
    rst = 1'b0; dcAck = 1'b0; dcErr = 1'b0; dcRdData = '0;
    set_in(6'h00, 0, 0, 0, 1'b0);
    #2;
    chk("rst_outValid", {31'b0, outValid}, 0);
    chk("rst_dcReq",    {31'b0, dcReq},    0);
    chk("rst_stall",    {31'b0, stallOut}, 0);
    chk("rst_trap",     {28'b0, trapCode}, 0);
    @(negedge clk); rst = 1'b1;

    // Pass-through ADD
    set_in(OP_ADD, 5, 7, 3, 1'b1);
    tick();
    chk("add_p0_valid", {31'b0, outValid}, 0);
    chk("add_p0_req",   {31'b0, dcReq},    0);
    tick();
    chk("add_A",     outValA, 5);
    chk("add_B",     outValB, 7);
    chk("add_X",     outValX, 3);
    chk("add_valid", {31'b0, outValid}, 1);
    chk("add_instr", outInstr, {OP_ADD, 26'h0ABCDE});
    chk("add_req",   {31'b0, dcReq}, 0);

    // Load, ack 3 clks after request
    set_in(OP_LD, 32'h11, 32'h1000, 32'h24, 1'b1);
    tick();
    chk("ld_req",   {31'b0, dcReq}, 1);
    chk("ld_wr",    {31'b0, dcWr},  0);
    chk("ld_adr",   dcAdr, 32'h1024);
    mem_wait(3, 32'hDEADBEEF, 1'b0, stall_clks);
    chk("ld_stall_clks", stall_clks, 3);
    chk("ld_req_drop", {31'b0, dcReq},    0);
    chk("ld_stall_end", {31'b0, stallOut}, 0);
    tick();
    chk("ld_B",     outValB, 32'hDEADBEEF);
    chk("ld_X",     outValX, 32'h1024);
    chk("ld_A",     outValA, 32'h11);
    chk("ld_valid", {31'b0, outValid}, 1);

    // Store with address wrap
    set_in(OP_ST, 32'h55, 32'hFFFFFFFC, 32'h8, 1'b1);
    tick();
    chk("st_wr",     {31'b0, dcWr}, 1);
    chk("st_wdata",  dcWrData, 32'h55);
    chk("st_adr",    dcAdr, 32'h4);
    chk("st_req",    {31'b0, dcReq}, 1);
    mem_wait(1, 32'h0, 1'b0, stall_clks);
    chk("st_stall_clks", stall_clks, 1);
    tick();
    chk("st_B",     outValB, 32'hFFFFFFFC);
    chk("st_X",     outValX, 32'h4);
    chk("st_valid", {31'b0, outValid}, 1);

    // Load with data error
    set_in(OP_LD, 32'h22, 32'h2000, 32'h0, 1'b1);
    tick();
    mem_wait(2, 32'hBAD0BAD0, 1'b1, stall_clks);
    chk("err_pre_trap", {31'b0, trapReq}, 0);
    chk("err_stall",    {31'b0, stallOut}, 0);
    tick();
    chk("err_trapReq",  {31'b0, trapReq}, 1);
    chk("err_trapCode", {28'b0, trapCode}, 1);
    chk("err_valid",    {31'b0, outValid}, 0);
    set_in(OP_ADD, 1, 2, 3, 1'b1);
    tick();
    chk("err_trap_clr", {31'b0, trapReq}, 0);
    chk("err_code_clr", {28'b0, trapCode}, 0);
    chk("err_no_req",   {31'b0, dcReq}, 0);
    tick();
    chk("post_err_valid", {31'b0, outValid}, 1);
    chk("post_err_A",     outValA, 1);
    chk("post_err_X",     outValX, 3);

    // Misaligned load
    set_in(OP_LD, 32'h33, 32'h1002, 32'h0, 1'b1);
    tick();
`ifdef MA_ALIGN_CHECK_EN
    chk("mis_no_req",   {31'b0, dcReq}, 0);
    chk("mis_no_stall", {31'b0, stallOut}, 0);
    tick();
    chk("mis_trapReq",  {31'b0, trapReq}, 1);
    chk("mis_trapCode", {28'b0, trapCode}, 2);
    chk("mis_valid",    {31'b0, outValid}, 0);
    set_in(OP_ADD, 0, 0, 0, 1'b0);
    tick();
    chk("mis_trap_clr", {31'b0, trapReq}, 0);
    tick();
`else
    chk("mis_req", {31'b0, dcReq}, 1);
    chk("mis_adr", dcAdr, 32'h1000);
    mem_wait(1, 32'h12345678, 1'b0, stall_clks);
    tick();
    chk("mis_B",     outValB, 32'h12345678);
    chk("mis_X",     outValX, 32'h1000);
    chk("mis_valid", {31'b0, outValid}, 1);
    chk("mis_notrap", {31'b0, trapReq}, 0);
`endif

    // Invalid LD: no request, bubble passes through
    set_in(OP_LD, 32'h44, 32'h3000, 32'h4, 1'b0);
    tick();
    chk("inv_req", {31'b0, dcReq}, 0);
    tick();
    chk("inv_valid", {31'b0, outValid}, 0);
    chk("inv_X",     outValX, 32'h4);

    // Reset mid-transaction, then a late ack must be ignored
    set_in(OP_LD, 32'h66, 32'h4000, 32'h10, 1'b1);
    tick();
    chk("mid_req",   {31'b0, dcReq},    1);
    chk("mid_stall", {31'b0, stallOut}, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_req",   {31'b0, dcReq},    0);
    chk("mid_rst_stall", {31'b0, stallOut}, 0);
    chk("mid_rst_A",     outValA, 0);
    chk("mid_rst_adr",   dcAdr, 0);
    @(negedge clk);
    rst = 1'b1;
    set_in(OP_ADD, 9, 8, 7, 1'b0);
    dcAck = 1'b1; dcRdData = 32'hFFFF0000;
    tick();
    chk("late_ack_stall", {31'b0, stallOut}, 0);
    chk("late_ack_req",   {31'b0, dcReq},    0);
    tick();
    dcAck = 1'b0;
    chk("late_ack_B",     outValB, 8);
    chk("late_ack_valid", {31'b0, outValid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
